axi_frame_reader: RTL and testbench

//  AXI4-full read master: fetches one stored frame (32-bit/pixel words, 0x00RRGGBB) from DDR in INCR bursts
//  and emits it as a 24-bit pixel stream with valid/ready, SOF and EOL flags. It is the read end of the frame

---
 rtl/axi_frame_reader.sv | 170 +++++++++++++++++
 tb/tb_axi_frame_reader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_frame_reader.sv
// axi_frame_reader: AXI4 burst reader that streams a stored 0x00RRGGBB frame out as 24-bit pixels
module axi_frame_reader #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int IMG_HDISP          = 960,
    parameter int IMG_VDISP          = 540,
    parameter int LINE_STRIDE        = 4096,
    parameter int FIFO_DEPTH         = 64
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          frame_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] frame_base,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [23:0]                   pix_data,
    output logic                          pix_sof,
    output logic                          pix_eol,
    output logic                          rresp_err
);
    localparam int PPB = C_M_AXI_DATA_WIDTH / 32;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int KW = PPB > 1 ? $clog2(PPB) : 1;
    localparam int XW = $clog2(IMG_HDISP + 1);
    localparam int YW = $clog2(IMG_VDISP + 1);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] STRIDE = AW'(LINE_STRIDE);
    localparam logic [AW-1:0] BBYTES = AW'(C_M_AXI_BURST_LEN * 16);
    localparam logic [AW-1:0] LAST_OFF = AW'(IMG_HDISP * 4 - C_M_AXI_BURST_LEN * 16);
    localparam logic [FW:0] LEN = (FW + 1)'(C_M_AXI_BURST_LEN);
    localparam logic [FW:0] RES_MAX = (FW + 1)'(FIFO_DEPTH - C_M_AXI_BURST_LEN);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_VDISP - 1);
    localparam logic [KW-1:0] K_LAST = KW'(PPB - 1);

    typedef enum logic [2:0] {IDLE, WAIT_SPACE, ADDR, DATA, DRAIN} state_t;

    state_t state;
    logic [PPB-1:0][23:0] mem [FIFO_DEPTH];
    logic [PPB-1:0][23:0] wdata, head;
    logic [8*PPB-1:0] unused_rdata;
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0] cnt, res;
    logic [KW-1:0] k;
    logic [XW-1:0] x;
    logic [YW-1:0] y, y_rd;
    logic [AW-1:0] line_addr, boff;
    logic wr, xfer, pop, res_inc, last_pix;

    assign M_AXI_ARID = 1'b0;
    assign M_AXI_ARLEN = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_ARSIZE = 3'd4;
    assign M_AXI_ARBURST = 2'b01;
    assign busy = state != IDLE;
    assign wr = M_AXI_RVALID & M_AXI_RREADY;
    assign head = mem[rd_ptr];
    assign pix_valid = cnt != '0;
    assign pix_data = head[k];
    assign last_pix = x == X_LAST && y == Y_LAST;
    assign pix_sof = pix_valid & x == '0 & y == '0;
    assign pix_eol = pix_valid & x == X_LAST;
    assign xfer = pix_valid & pix_ready;
    assign pop = xfer & k == K_LAST;
    assign res_inc = state == WAIT_SPACE && res <= RES_MAX;

    // strip the unused top byte of every 32-bit word before it enters the FIFO
    always_comb begin
        for (int i = 0; i < PPB; i++) begin
            wdata[i] = M_AXI_RDATA[32*i +: 24];
            unused_rdata[8*i +: 8] = M_AXI_RDATA[32*i+24 +: 8];
        end
    end

    // beat storage; no reset needed since occupancy is tracked separately
    always_ff @(posedge M_AXI_ACLK) begin
        if (wr) mem[wr_ptr] <= wdata;
    end

    // FIFO pointers, space reservation, sub-beat index and pixel x/y position
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            res <= '0;
            k <= '0;
            x <= '0;
            y <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + FW'(1);
            if (pop) rd_ptr <= rd_ptr + FW'(1);
            cnt <= cnt + (FW + 1)'(wr) - (FW + 1)'(pop);
            res <= res + (res_inc ? LEN : '0) - (FW + 1)'(pop);
            if (xfer) begin
                k <= k == K_LAST ? '0 : k + KW'(1);
                x <= x == X_LAST ? '0 : x + XW'(1);
                if (x == X_LAST) y <= y == Y_LAST ? '0 : y + YW'(1);
            end
        end
    end

    // burst sequencing: reserve space, issue address, accept beats, then drain the last pixels
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state <= IDLE;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR <= '0;
            M_AXI_RREADY <= 1'b0;
            frame_done <= 1'b0;
            rresp_err <= 1'b0;
            line_addr <= '0;
            boff <= '0;
            y_rd <= '0;
        end else begin
            frame_done <= 1'b0;
            if (wr && M_AXI_RRESP != 2'b00) rresp_err <= 1'b1;
            case (state)
                IDLE: if (frame_start) begin
                    state <= WAIT_SPACE;
                    line_addr <= frame_base;
                    boff <= '0;
                    y_rd <= '0;
                    rresp_err <= 1'b0;
                end
                WAIT_SPACE: if (res_inc) begin
                    state <= ADDR;
                    M_AXI_ARVALID <= 1'b1;
                    M_AXI_ARADDR <= line_addr + boff;
                end
                ADDR: if (M_AXI_ARREADY) begin
                    state <= DATA;
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY <= 1'b1;
                end
                DATA: if (wr && M_AXI_RLAST) begin
                    M_AXI_RREADY <= 1'b0;
                    if (boff == LAST_OFF) begin
                        boff <= '0;
                        line_addr <= line_addr + STRIDE;
                        y_rd <= y_rd + YW'(1);
                        state <= y_rd == Y_LAST ? DRAIN : WAIT_SPACE;
                    end else begin
                        boff <= boff + BBYTES;
                        state <= WAIT_SPACE;
                    end
                end
                DRAIN: if (xfer && last_pix) begin
                    state <= IDLE;
                    frame_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_frame_reader.sv
// tb_axi_frame_reader: random-stall AXI slave plus frame-level reference model for axi_frame_reader
module tb_axi_frame_reader;
    localparam int AW = 32, DW = 128, LEN = 4, H = 32, V = 4, STRIDE = 256, DEPTH = 16;

    logic clk = 0;
    always #5 clk = ~clk;

    logic ARESETN, frame_start, busy, frame_done;
    logic [AW-1:0] frame_base, ARADDR;
    logic ARID, ARVALID, ARREADY, RRESP_unused_dummy;
    logic [7:0] ARLEN;
    logic [2:0] ARSIZE;
    logic [1:0] ARBURST, RRESP;
    logic [DW-1:0] RDATA;
    logic RLAST, RVALID, RREADY, pix_valid, pix_ready, pix_sof, pix_eol, rresp_err;
    logic [23:0] pix_data;

    axi_frame_reader #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_BURST_LEN(LEN),
        .IMG_HDISP(H), .IMG_VDISP(V), .LINE_STRIDE(STRIDE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(ARESETN), .frame_start(frame_start), .frame_base(frame_base),
        .busy(busy), .frame_done(frame_done), .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR),
        .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST), .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .rresp_err(rresp_err)
    );

    int vectors = 0, miscompares = 0;
    int pr_rate = 100, slv_rate = 100;
    logic pr_hold = 0;
    logic [31:0] err_addr = '1;

    // memory contents: every 32-bit word is a unique function of its byte address, top byte is junk
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[9:2] ^ 8'hA5, (a[23:0] * 24'd40503) ^ 24'h3C5A96};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI read slave: random ARREADY/RVALID, one burst queue, optional error response on one address
    logic [31:0] rq[$];
    int beat = 0;
    initial begin
        logic hs, rst;
        logic [31:0] a;
        ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 0; RLAST = 0;
        forever begin
            @(negedge clk);
            hs = RVALID && RREADY;
            rst = !ARESETN;
            if (rst) begin
                rq.delete();
                beat = 0;
            end else begin
                if (ARVALID && ARREADY) rq.push_back(ARADDR);
                if (hs) begin
                    if (beat == LEN - 1) begin
                        beat = 0;
                        void'(rq.pop_front());
                    end else beat++;
                end
            end
            @(posedge clk);
            #1;
            ARREADY = $urandom_range(99) < slv_rate;
            if (rst) RVALID = 0;
            else if (!RVALID || hs) begin
                if (rq.size() > 0 && $urandom_range(99) < slv_rate) begin
                    RVALID = 1;
                    a = rq[0] + 32'(beat * 16);
                    for (int i = 0; i < DW / 32; i++) RDATA[32*i +: 32] = mem_word(a + 32'(4 * i));
                    RLAST = beat == LEN - 1;
                    RRESP = rq[0] == err_addr ? 2'b10 : 2'b00;
                end else RVALID = 0;
            end
        end
    end

    // downstream sink
    initial begin
        pix_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = !pr_hold && ($urandom_range(99) < pr_rate);
        end
    end

    // reference model: on an accepted start the whole frame's pixels and burst addresses are queued
    typedef struct {logic [23:0] d; logic sof, eol, last;} pix_t;
    pix_t exp_pix[$];
    logic [31:0] exp_ar[$];
    logic busy_e = 0, done_e = 0, err_e = 0;
    logic pv_q = 0, pr_q = 0, av_q = 0, ar_q = 0, sof_q, eol_q;
    logic [23:0] pd_q;
    logic [31:0] aa_q;
    logic [31:0] ar_log [3];
    int beats_rx = 0, pix_out = 0, frames_acc = 0;
    int ar_frame = 0, pix_cnt = 0, sof_cnt = 0, eol_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        pix_t e;
        logic [31:0] w;
        logic done_n, err_n, start_acc;
        done_n = 0;
        err_n = 0;
        chk("busy", busy, busy_e);
        chk("frame_done", frame_done, done_e);
        chk("rresp_err", rresp_err, err_e);
        if (frame_done) done_cnt++;
        if (pv_q && !pr_q) begin
            chk("pix_hold_valid", pix_valid, 1);
            chk("pix_hold_data", {pix_sof, pix_eol, pix_data}, {sof_q, eol_q, pd_q});
        end
        if (av_q && !ar_q) chk("ar_hold", {ARVALID, ARADDR}, {1'b1, aa_q});
        if (pix_valid && pix_ready) begin
            if (exp_pix.size() == 0) chk("pix_unexpected", 1, 0);
            else begin
                e = exp_pix.pop_front();
                chk("pix_data", pix_data, e.d);
                chk("pix_flags", {pix_sof, pix_eol}, {e.sof, e.eol});
                done_n = e.last;
            end
            pix_out++;
            pix_cnt++;
            sof_cnt += int'(pix_sof);
            eol_cnt += int'(pix_eol);
        end
        if (ARVALID && ARREADY) begin
            if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
            else chk("araddr", ARADDR, exp_ar.pop_front());
            chk("ar_fields", {ARID, ARLEN, ARSIZE, ARBURST}, {1'b0, 8'd3, 3'd4, 2'b01});
            if (ar_frame < 3) ar_log[ar_frame] = ARADDR;
            ar_frame++;
        end
        if (RVALID && RREADY) begin
            beats_rx++;
            chk("fifo_no_overflow", (beats_rx - pix_out / 4) <= DEPTH, 1);
            err_n = RRESP != 2'b00;
        end
        start_acc = frame_start && !busy_e && ARESETN;
        if (start_acc) begin
            frames_acc++;
            for (int y = 0; y < V; y++) begin
                for (int x = 0; x < H; x++) begin
                    w = mem_word(frame_base + 32'(y * STRIDE + x * 4));
                    e.d = w[23:0];
                    e.sof = x == 0 && y == 0;
                    e.eol = x == H - 1;
                    e.last = x == H - 1 && y == V - 1;
                    exp_pix.push_back(e);
                end
                for (int b = 0; b < H * 4 / (LEN * 16); b++)
                    exp_ar.push_back(frame_base + 32'(y * STRIDE + b * LEN * 16));
            end
        end
        busy_e = !ARESETN ? 0 : start_acc ? 1 : done_n ? 0 : busy_e;
        done_e = ARESETN && done_n;
        err_e = !ARESETN ? 0 : start_acc ? 0 : err_n ? 1 : err_e;
        if (!ARESETN) begin
            exp_pix.delete();
            exp_ar.delete();
            beats_rx = 0;
            pix_out = 0;
        end
        pv_q = pix_valid && ARESETN;
        pr_q = pix_ready;
        pd_q = pix_data;
        sof_q = pix_sof;
        eol_q = pix_eol;
        av_q = ARVALID && ARESETN;
        ar_q = ARREADY;
        aa_q = ARADDR;
    end

    task automatic start(input logic [31:0] b);
        @(posedge clk);
        #1;
        ar_frame = 0; pix_cnt = 0; sof_cnt = 0; eol_cnt = 0; done_cnt = 0;
        frame_base = b;
        frame_start = 1;
        @(posedge clk);
        #1;
        frame_start = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 5000);
        if (busy !== 1'b0) chk(name, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (frames_acc < target && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (frames_acc < target) chk("start_accept_timeout", frames_acc, target);
    endtask

    initial begin
        int n;
        ARESETN = 0; frame_start = 0; frame_base = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {busy, frame_done, ARVALID, RREADY, pix_valid, rresp_err}, 0);
        chk("rst_araddr", ARADDR, 0);
        @(posedge clk);
        #1 ARESETN = 1;

        // zero-wait frame with literal expectations
        start(32'h0001_0000);
        wait_idle("f1_timeout");
        chk("f1_ar0", ar_log[0], 32'h0001_0000);
        chk("f1_ar1", ar_log[1], 32'h0001_0040);
        chk("f1_ar2", ar_log[2], 32'h0001_0100);
        chk("f1_bursts", ar_frame, 8);
        chk("f1_pixels", pix_cnt, 128);
        chk("f1_sof", sof_cnt, 1);
        chk("f1_eol", eol_cnt, 4);
        chk("f1_done", done_cnt, 1);

        // downstream blocked: reads stop once the FIFO is fully reserved
        pr_hold = 1;
        start(32'h0002_0000);
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("stall_bursts", ar_frame, 4);
        chk("stall_arvalid", ARVALID, 0);
        chk("stall_rready", RREADY, 0);
        chk("stall_pix_valid", pix_valid, 1);
        @(posedge clk);
        #1 frame_base = 32'h0009_0000; frame_start = 1;
        @(posedge clk);
        #1 frame_start = 0;
        pr_hold = 0;
        wait_idle("stall_timeout");
        chk("stall_bursts_total", ar_frame, 8);

        // three back-to-back frames under random stalls, start held high across busy
        pr_rate = 60; slv_rate = 50;
        n = frames_acc;
        @(posedge clk);
        #1 frame_base = 32'h0003_0000; frame_start = 1;
        wait_acc(n + 1);
        frame_base = 32'h0004_0000;
        wait_acc(n + 2);
        frame_base = 32'h0005_0000;
        wait_acc(n + 3);
        frame_start = 0;
        wait_idle("b2b_timeout");
        chk("b2b_frames", frames_acc, n + 3);

        // error response on the fourth burst
        err_addr = 32'h0006_0140;
        start(32'h0006_0000);
        wait_idle("err_timeout");
        chk("err_sticky", rresp_err, 1);
        err_addr = '1;
        start(32'h0007_0000);
        @(negedge clk);
        chk("err_cleared", rresp_err, 0);
        wait_idle("err2_timeout");

        // reset in the middle of a data phase
        start(32'h0008_0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(RREADY && ar_frame >= 2) && n < 3000);
        if (!(RREADY && ar_frame >= 2)) chk("midrst_wait", 0, 1);
        @(posedge clk);
        #1 ARESETN = 0;
        @(posedge clk);
        #1 ARESETN = 1;
        @(negedge clk);
        chk("midrst_outputs", {busy, frame_done, ARVALID, RREADY, pix_valid, rresp_err}, 0);
        chk("midrst_araddr", ARADDR, 0);
        start(32'h000A_0000);
        wait_idle("post_rst_timeout");
        chk("post_rst_pixels", pix_cnt, 128);
        chk("post_rst_done", done_cnt, 1);
        chk("queues_empty", exp_pix.size() + exp_ar.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1);
    end
endmodule
